conv_frame_sequencer: RTL and testbench
=======================================

// Module: conv_frame_sequencer
// PURPOSE
//  Sequences one frame of the 3x3 Sobel convolution datapath. Accepts a raster pixel stream and
//  tracks column/row. Drives wr/rd of the two IMG_W-deep line-buffer FIFOs (bot = row r-1,
//  top = row r-2). Flags which cycles carry a complete interior 3x3 window. Flushes the
//  buffers at end of frame so the next frame starts from empty.
//  Sits between the camera/pixel source and the convolution datapath and its 9-tap filter grid.
// PARAMETERS
//  IMG_W  640  pixels per line; also the required line-FIFO depth
//  IMG_H  480  lines per frame (must be >= 3)
//  CW     $clog2(IMG_W)  column counter width (derived, localparam)
//  RW     $clog2(IMG_H)  row counter width (derived, localparam)
// PORTS
//  clk         in   1   rising-edge clock
//  rst         in   1   synchronous, active-high reset
//  start       in   1   one-cycle request to begin a frame; sampled only in IDLE
//  vertical_in in   1   filter orientation; latched on accepted start
//  pix_valid   in   1   source has a pixel this cycle
//  pix_ready   out  1   sequencer accepts pixel (accept = pix_valid & pix_ready)
//  bot_wr      out  1   write current pixel into bot FIFO
//  bot_rd      out  1   pop bot FIFO (row r-1 sample), same cycle feeds top FIFO
//  top_wr      out  1   push bot FIFO output into top FIFO
//  top_rd      out  1   pop top FIFO (row r-2 sample)
//  col         out  CW  column of the accepted pixel
//  row         out  RW  row of the accepted pixel
//  vertical    out  1   latched orientation for the whole frame
//  win_valid   out  1   registered: datapath sum this cycle is a valid interior window
//  busy        out  1   high from accepted start until frame_done
//  frame_done  out  1   one-cycle pulse after flush completes
// BEHAVIOUR
//  Reset: state=IDLE, col=row=0, every output 0, vertical=0. The FIFOs need not be cleared by
//   this block; a mid-frame rst abandons the frame, and the datapath owner resets the FIFOs.
//  FSM:
//   IDLE  : pix_ready=0. start -> FILL, clear col/row, latch vertical.
//   FILL  : row 0..1. pix_ready=1; accept -> bot_wr=1. On row 1: bot_rd=top_wr=1.
//           At col=IMG_W-1, row=1 -> RUN.
//   RUN   : rows 2..IMG_H-1. Each accept -> bot_wr=bot_rd=top_wr=top_rd=1.
//           At the last pixel (col=IMG_W-1, row=IMG_H-1) -> FLUSH.
//   FLUSH : pix_ready=0. bot_rd=top_rd=1 every cycle for exactly IMG_W cycles
//           (bot_wr=top_wr=0), then -> DONE.
//   DONE  : frame_done=1 for one cycle, busy=0 -> IDLE.
//  Counters advance only on accept. col wraps IMG_W-1 -> 0 and increments row. No pixel is
//   accepted after the last one.
//  win_valid: registered one cycle after an accept in RUN with col>=2. The window is then
//   centred at (row-1, col-1). A frame yields exactly (IMG_H-2)*(IMG_W-2) win_valid pulses;
//   border windows are suppressed.
//  Stall: pix_valid=0 freezes counters and all FIFO strobes (all 0); state holds.
//  start while busy is ignored. rst has priority over every event, in any state.
//  No FIFO is ever read when empty or written when full. The bench asserts this with the
//   FIFO flags.
// STRUCTURE
//  Package conv_pkg: typedef enum logic [2:0] {IDLE,FILL,RUN,FLUSH,DONE} seq_state_e;
//   default IMG_W/IMG_H localparams. The same package is shared with the convolution datapath.
//  Sub-module pix_counter: col/row raster counter with wrap and an end-of-frame flag.
//   FSM and strobe decode stay in this file.
// TESTING (IMG_W=4, IMG_H=4 unless noted)
//  1. rst high mid-RUN -> next cycle state IDLE, busy=0, pix_ready=0, all strobes 0.
//  2. start, 16 back-to-back pixels -> exactly 4 win_valid pulses, at accepts (2,2),(2,3),
//     (3,2),(3,3) +1 cycle.
//  3. Same frame, then FLUSH -> 4 cycles of bot_rd=top_rd=1, then frame_done one cycle;
//     FIFOs empty.
//  4. pix_valid toggling 1/0 every cycle -> identical win_valid count (4) and strobes only
//     on accept cycles.
//  5. start with vertical_in=1, then vertical_in=0 mid-frame -> vertical stays 1 until
//     frame_done; start while busy ignored.
//  6. IMG_W=640, IMG_H=480 with the real FIFO model -> 478*638 win_valid pulses;
//     no full/empty violation.

Source files
------------

// File: rtl/conv_frame_sequencer_pkg.sv
// Shared definitions for the Sobel frame sequencer and the convolution datapath.
// Holds the sequencer state encoding and the default frame geometry.
package conv_pkg;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/conv_frame_sequencer_pix_counter.sv
// Raster column/row counter for the frame sequencer.
// Advances only on accepted pixels and flags the last pixel of the frame.
module pix_counter #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  localparam int CW = $clog2(IMG_W),
  localparam int RW = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          adv,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          col_end;
  logic          row_end;

  assign col_end = (col_q == CW'(IMG_W - 1));
  assign row_end = (row_q == RW'(IMG_H - 1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (adv) begin
      if (col_end) begin
        col_d = '0;
        // The row also wraps after the final pixel so the counter never overflows RW.
        row_d = row_end ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = col_end && row_end;

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame sequencer for the 3x3 Sobel datapath: accepts a raster stream, drives the two
// line-buffer FIFOs, flags interior windows and flushes the buffers at end of frame.
module conv_frame_sequencer
  import conv_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  localparam int CW = $clog2(IMG_W),
  localparam int RW = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          vertical_in,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic          bot_wr,
  output logic          bot_rd,
  output logic          top_wr,
  output logic          top_rd,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          vertical,
  output logic          win_valid,
  output logic          busy,
  output logic          frame_done,
  output seq_state_e    state
);

  // Handshake: a pixel transfers on a cycle where pix_valid and pix_ready are both high;
  // pix_ready does not depend on pix_valid, and nothing moves on any other cycle.

  seq_state_e    state_q, state_d;
  logic [CW-1:0] flush_q, flush_d;
  logic          vertical_q, vertical_d;
  logic          win_q, win_d;
  logic          accept;
  logic          start_ok;
  logic          last_pix;
  logic          flush_end;

  assign start_ok  = (state_q == IDLE) && start;
  assign accept    = pix_valid && pix_ready;
  assign flush_end = (flush_q == CW'(IMG_W - 1));

  pix_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (start_ok),
    .adv   (accept),
    .col   (col),
    .row   (row),
    .last  (last_pix)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      flush_q    <= '0;
      vertical_q <= 1'b0;
      win_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      flush_q    <= flush_d;
      vertical_q <= vertical_d;
      win_q      <= win_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = FILL;
      FILL:  if (accept && col == CW'(IMG_W - 1) && row == RW'(1)) state_d = RUN;
      RUN:   if (accept && last_pix) state_d = FLUSH;
      FLUSH: if (flush_end) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flush_d    = (state_q == FLUSH) ? flush_q + CW'(1) : '0;
    vertical_d = start_ok ? vertical_in : vertical_q;
    // Window centre lags the accepted pixel by one row and one column.
    win_d      = accept && (state_q == RUN) && (col >= CW'(2));
  end

  always_comb begin
    pix_ready  = 1'b0;
    bot_wr     = 1'b0;
    bot_rd     = 1'b0;
    top_wr     = 1'b0;
    top_rd     = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      FILL: begin
        pix_ready = !rst;
        busy      = 1'b1;
        bot_wr    = accept;
        bot_rd    = accept && (row == RW'(1));
        top_wr    = accept && (row == RW'(1));
      end
      RUN: begin
        pix_ready = !rst;
        busy      = 1'b1;
        bot_wr    = accept;
        bot_rd    = accept;
        top_wr    = accept;
        top_rd    = accept;
      end
      FLUSH: begin
        busy   = 1'b1;
        bot_rd = !rst;
        top_rd = !rst;
      end
      DONE:    frame_done = 1'b1;
      default: ;
    endcase
  end

  assign vertical  = vertical_q;
  assign win_valid = win_q;
  assign state     = state_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Bench for conv_frame_sequencer on a 4x4 frame: raster-index model of the stream,
// FIFO occupancy model and literal window positions.
module tb_conv_frame_sequencer;
  import conv_pkg::*;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       vertical_in = 1'b0;
  logic       pix_valid = 1'b0;
  logic       pix_ready, bot_wr, bot_rd, top_wr, top_rd;
  logic [1:0] col;
  logic [1:0] row;
  logic       vertical, win_valid, busy, frame_done;
  seq_state_e dut_state;

  int checks = 0;
  int failures = 0;

  conv_frame_sequencer #(.IMG_W(W), .IMG_H(H)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .vertical_in (vertical_in),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .bot_wr      (bot_wr),
    .bot_rd      (bot_rd),
    .top_wr      (top_wr),
    .top_rd      (top_rd),
    .col         (col),
    .row         (row),
    .vertical    (vertical),
    .win_valid   (win_valid),
    .busy        (busy),
    .frame_done  (frame_done),
    .state       (dut_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: frame phase, accepted-pixel index, FIFO occupancy
  int         m_mode = 0;   // 0 idle, 1 streaming, 2 flushing, 3 done
  int         m_n = 0;
  int         m_flush = 0;
  bit         m_win = 0;
  bit         m_vert = 0;
  logic [7:0] m_prev_rc = '0;
  int         bot_cnt = 0;
  int         top_cnt = 0;
  int         frame_win = 0;
  int         flush_seen = 0;
  bit         done_seen = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  // compare process: outputs are packed {pix_ready,bot_wr,bot_rd,top_wr,top_rd,busy,frame_done}
  always @(negedge clk) begin
    logic [6:0] exp_o;
    logic [6:0] act_o;
    int r, c;
    bit acc;
    act_o = {pix_ready, bot_wr, bot_rd, top_wr, top_rd, busy, frame_done};
    if (rst) begin
      m_mode = 0; m_win = 0; m_vert = 0; bot_cnt = 0; top_cnt = 0;
    end else begin
      exp_o = '0;
      acc = 0; r = m_n / W; c = m_n % W;
      case (m_mode)
        0: chk("state_idle", int'(dut_state), int'(IDLE));
        1: begin
          acc = pix_valid;
          exp_o = {1'b1, acc, acc && r >= 1, acc && r >= 1, acc && r >= 2, 1'b1, 1'b0};
          chk("col", int'(col), c);
          chk("row", int'(row), r);
        end
        2: exp_o = 7'b0010110;
        default: exp_o = 7'b0000001;
      endcase
      chk("outs", int'(act_o), int'(exp_o));
      chk("win_valid", int'(win_valid), int'(m_win));
      chk("vertical", int'(vertical), int'(m_vert));
      if (win_valid) begin
        frame_win++;
        got_q.push_back(m_prev_rc);
      end
      if (frame_done) done_seen = 1;
      if (m_mode == 2 && bot_rd && top_rd && !pix_ready) flush_seen++;
      if (bot_rd) chk("bot_not_empty", int'(bot_cnt == 0), 0);
      if (bot_wr && !bot_rd) chk("bot_not_full", int'(bot_cnt == W), 0);
      if (top_rd) chk("top_not_empty", int'(top_cnt == 0), 0);
      if (top_wr && !top_rd) chk("top_not_full", int'(top_cnt == W), 0);
      bot_cnt += int'(bot_wr) - int'(bot_rd);
      top_cnt += int'(top_wr) - int'(top_rd);
      // advance model to the next cycle
      m_win = 0;
      case (m_mode)
        0: if (start) begin m_mode = 1; m_n = 0; m_vert = vertical_in; end
        1: if (acc) begin
          m_win = (r >= 2) && (c >= 2);
          m_prev_rc = {4'(r), 4'(c)};
          m_n++;
          if (m_n == W * H) begin m_mode = 2; m_flush = W; end
        end
        2: begin m_flush--; if (m_flush == 0) m_mode = 3; end
        default: m_mode = 0;
      endcase
    end
  end

  // driver: pattern 0 back-to-back, 1 toggling, 2 pseudo-random gaps
  task automatic run_frame(input logic vert, input int pattern);
    frame_win = 0; flush_seen = 0; done_seen = 0;
    got_q.delete();
    @(posedge clk); #1 start = 1'b1; vertical_in = vert;
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
      case (pattern)
        0: pix_valid = 1'b1;
        1: pix_valid = (cyc % 2 == 0);
        default: pix_valid = ($urandom_range(0, 3) != 0);
      endcase
      if (cyc == 6) begin start = 1'b1; vertical_in = !vert; end
      if (cyc == 7) start = 1'b0;
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    chk("frame_done_seen", int'(done_seen), 1);
    chk("win_count", frame_win, 4);
    chk("flush_cycles", flush_seen, 4);
    chk("bot_empty", bot_cnt, 0);
    chk("top_empty", top_cnt, 0);
    chk("win_pos_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("win_pos", int'(got_q[i]), int'(exp_q[i]));
  endtask

  initial begin
    exp_q = '{8'h22, 8'h23, 8'h32, 8'h33};
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(pix_ready), 0);
    chk("rst_colrow", int'({col, row}), 0);
    chk("rst_vertical", int'(vertical), 0);
    @(posedge clk); #1;

    run_frame(1'b1, 0);
    run_frame(1'b0, 1);
    run_frame(1'b1, 2);

    // abandon a frame in RUN
    @(posedge clk); #1 start = 1'b1; vertical_in = 1'b1;
    @(posedge clk); #1 start = 1'b0; pix_valid = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    chk("mid_run_state", int'(dut_state), int'(RUN));
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; pix_valid = 1'b1;
    @(negedge clk);
    chk("post_rst_state", int'(dut_state), int'(IDLE));
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_ready", int'(pix_ready), 0);
    chk("post_rst_strobes", int'({bot_wr, bot_rd, top_wr, top_rd}), 0);
    @(posedge clk); #1 pix_valid = 1'b0;

    run_frame(1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
